// File: rtl/zf_dma_scheduler.sv
`default_nettype none
//==============================================================================
// Module : zf_dma_scheduler
// Brief  : Per-channel DMA command queues with work-conserving round-robin
//          issue of 72-bit datamover commands, status matching through an
//          in-flight queue, and a coalesced per-channel maskable interrupt.
// Ports  : clk/rst          clock, asynchronous active-high reset
//          set_stb/addr/data settings write ([7:4] channel, [3:0] register)
//          rb_stb/addr/data  readback request and registered readback data
//          ch_ready          per-channel stream readiness
//          cmd_*             datamover command stream plus issuing channel
//          sts_*             datamover status stream
//          irq               OR of per-channel pending-and-enabled bits
// Rev    : 1.0  initial release
//==============================================================================
module zf_dma_scheduler #(
  parameter int CHAN_WIDTH     = 2,
  parameter int CMD_DEPTH_LOG2 = 4,
  parameter int BTT_WIDTH      = 23
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_stb,
  input  logic [7:0]                   set_addr,
  input  logic [31:0]                  set_data,
  input  logic                         rb_stb,
  input  logic [7:0]                   rb_addr,
  output logic [31:0]                  rb_data,
  input  logic [(1<<CHAN_WIDTH)-1:0]   ch_ready,
  output logic [71:0]                  cmd_tdata,
  output logic                         cmd_tvalid,
  input  logic                         cmd_tready,
  output logic [CHAN_WIDTH-1:0]        cmd_chan,
  input  logic [7:0]                   sts_tdata,
  input  logic                         sts_tvalid,
  output logic                         sts_tready,
  output logic                         irq
);

  localparam int c_NUM_CHAN = 1 << CHAN_WIDTH;
  localparam int c_DEPTH    = 1 << CMD_DEPTH_LOG2;
  localparam int c_PW       = CMD_DEPTH_LOG2;
  localparam int c_IFW      = CHAN_WIDTH + 4;

  localparam logic [0:0] c_S_IDLE  = 1'b0;
  localparam logic [0:0] c_S_ISSUE = 1'b1;

  // Settings decode; channel numbers beyond the channel count are dropped.
  logic                  w_set_ok;
  logic [CHAN_WIDTH-1:0] w_set_chan;
  logic [3:0]            w_set_reg;
  logic                  w_btt_zero;

  assign w_set_ok   = set_stb && ((set_addr[7:4] >> CHAN_WIDTH) == 4'd0);
  assign w_set_chan = set_addr[4 +: CHAN_WIDTH];
  assign w_set_reg  = set_addr[3:0];
  assign w_btt_zero = (set_data[BTT_WIDTH-1:0] == '0);

  // Scheduler state
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic                  w_grant;
  logic                  w_issue_done;
  logic                  w_any_elig;
  logic [CHAN_WIDTH-1:0] w_sel;
  logic [CHAN_WIDTH-1:0] w_rr_idx;
  logic [CHAN_WIDTH-1:0] r_last_grant;
  logic [CHAN_WIDTH-1:0] r_cmd_chan;
  logic [3:0]            r_tag;
  logic                  r_cmd_tvalid;
  logic [71:0]           r_cmd_tdata;

  // In-flight queue of {channel, tag}
  logic [c_IFW-1:0]      r_if_mem [c_DEPTH];
  logic [c_PW-1:0]       r_if_wr;
  logic [c_PW-1:0]       r_if_rd;
  logic [c_PW:0]         r_if_occ;
  logic                  w_if_full;
  logic                  w_if_empty;
  logic                  w_sts_hs;
  logic [c_IFW-1:0]      w_if_head;
  logic [CHAN_WIDTH-1:0] w_if_chan;
  logic [3:0]            w_if_tag;

  // Per-channel views
  logic [c_NUM_CHAN-1:0]                 w_full;
  logic [c_NUM_CHAN-1:0]                 w_empty;
  logic [c_NUM_CHAN-1:0]                 w_pop;
  logic [c_NUM_CHAN-1:0]                 w_elig;
  logic [c_NUM_CHAN-1:0]                 w_irq_out;
  logic [c_NUM_CHAN-1:0][31:0]           w_head_addr;
  logic [c_NUM_CHAN-1:0][BTT_WIDTH-1:0]  w_head_btt;
  logic [c_NUM_CHAN-1:0][31:0]           w_rb0;
  logic [c_NUM_CHAN-1:0][31:0]           w_rb1;
  logic [c_NUM_CHAN-1:0][31:0]           w_rb2;

  logic        r_irq;
  logic [31:0] r_rb_data;

  // Only the OKAY bit of the status error field is acted on.
  logic w_unused;
  assign w_unused = &{1'b0, sts_tdata[6:4]};

  assign w_if_full  = r_if_occ[c_PW];
  assign w_if_empty = (r_if_occ == '0);
  assign w_if_head  = r_if_mem[r_if_rd];
  assign w_if_chan  = w_if_head[c_IFW-1:4];
  assign w_if_tag   = w_if_head[3:0];
  assign w_sts_hs   = sts_tvalid && !w_if_empty;

  assign w_elig = ~w_empty & ch_ready & {c_NUM_CHAN{~w_if_full}};

  //--------------------------------------------------------------------------
  // Per-channel command queue, counters, error bits and interrupt state
  //--------------------------------------------------------------------------
  for (genvar gi = 0; gi < c_NUM_CHAN; gi++) begin : g_chan
    logic [31:0]          r_addr;
    logic [31:0]          r_mem_addr [c_DEPTH];
    logic [BTT_WIDTH-1:0] r_mem_btt  [c_DEPTH];
    logic [c_PW-1:0]      r_wr_ptr;
    logic [c_PW-1:0]      r_rd_ptr;
    logic [c_PW:0]        r_occ;
    logic [7:0]           r_thresh;
    logic                 r_en;
    logic [15:0]          r_done;
    logic [7:0]           r_pend;
    logic                 r_irq_pend;
    logic [3:0]           r_err;       // {overflow, zero-length, tag mismatch, dm error}

    logic                 w_me;
    logic                 w_len_wr;
    logic                 w_push;
    logic                 w_ovf;
    logic                 w_zlen;
    logic                 w_cpl;
    logic                 w_ack_cnt;
    logic                 w_ack_err;
    logic                 w_cfg_wr;
    logic [7:0]           w_pend_nxt;
    logic                 w_irq_pend_nxt;
    logic                 w_en_nxt;
    logic [3:0]           w_err_nxt;

    assign w_me      = w_set_ok && (w_set_chan == CHAN_WIDTH'(gi));
    assign w_len_wr  = w_me && (w_set_reg == 4'd1);
    assign w_cfg_wr  = w_me && (w_set_reg == 4'd2);
    assign w_ack_cnt = w_me && (w_set_reg == 4'd3) && set_data[0];
    assign w_ack_err = w_me && (w_set_reg == 4'd3) && set_data[1];

    assign w_full[gi]  = r_occ[c_PW];
    assign w_empty[gi] = (r_occ == '0);
    assign w_pop[gi]   = w_grant && (w_sel == CHAN_WIDTH'(gi));

    // A full queue still accepts a push when its head leaves in the same cycle.
    assign w_push = w_len_wr && !w_btt_zero && (!w_full[gi] || w_pop[gi]);
    assign w_ovf  = w_len_wr && !w_btt_zero && w_full[gi] && !w_pop[gi];
    assign w_zlen = w_len_wr && w_btt_zero;
    assign w_cpl  = w_sts_hs && (w_if_chan == CHAN_WIDTH'(gi));

    always_comb begin
      w_pend_nxt = r_pend;
      if (w_ack_cnt) begin
        w_pend_nxt = w_cpl ? 8'd1 : 8'd0;
      end else if (w_cpl && (r_pend != 8'hff)) begin
        w_pend_nxt = r_pend + 8'd1;
      end
      // Threshold is compared against the post-update count, so an ACK that
      // coincides with a completion re-evaluates against a count of one.
      w_irq_pend_nxt = (r_irq_pend && !w_ack_cnt) ||
                       (w_cpl && (r_thresh != 8'd0) && (w_pend_nxt >= r_thresh));
      w_en_nxt  = w_cfg_wr ? set_data[0] : r_en;
      w_err_nxt = w_ack_err ? 4'd0 : r_err;
      w_err_nxt = w_err_nxt | {w_ovf, w_zlen,
                               w_cpl && (w_if_tag != sts_tdata[3:0]),
                               w_cpl && !sts_tdata[7]};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_addr     <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_occ      <= '0;
        r_thresh   <= '0;
        r_en       <= 1'b0;
        r_done     <= '0;
        r_pend     <= '0;
        r_irq_pend <= 1'b0;
        r_err      <= '0;
      end else begin
        if (w_me && (w_set_reg == 4'd0)) r_addr <= set_data;
        if (w_cfg_wr) r_thresh <= set_data[15:8];
        r_en <= w_en_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop[gi]})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
        if (w_cpl) r_done <= r_done + 16'd1;
        r_pend     <= w_pend_nxt;
        r_irq_pend <= w_irq_pend_nxt;
        r_err      <= w_err_nxt;
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem_addr[r_wr_ptr] <= r_addr;
        r_mem_btt[r_wr_ptr]  <= set_data[BTT_WIDTH-1:0];
      end
    end

    assign w_head_addr[gi] = r_mem_addr[r_rd_ptr];
    assign w_head_btt[gi]  = r_mem_btt[r_rd_ptr];
    assign w_irq_out[gi]   = w_irq_pend_nxt && w_en_nxt;
    assign w_rb0[gi] = {4'h0, r_err, r_pend, r_done};
    assign w_rb1[gi] = {r_occ[c_PW], (r_occ == '0), 14'h0, 16'(r_occ)};
    assign w_rb2[gi] = {16'h0, r_thresh, 7'h0, r_en};
  end

  //--------------------------------------------------------------------------
  // Round-robin search starting one past the last granted channel
  //--------------------------------------------------------------------------
  always_comb begin
    w_any_elig = 1'b0;
    w_sel      = r_last_grant;
    w_rr_idx   = '0;
    for (int i = 1; i <= c_NUM_CHAN; i++) begin
      w_rr_idx = r_last_grant + CHAN_WIDTH'(i);
      if (!w_any_elig && w_elig[w_rr_idx]) begin
        w_any_elig = 1'b1;
        w_sel      = w_rr_idx;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Scheduler FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:  if (w_any_elig) w_state_nxt = c_S_ISSUE;
      c_S_ISSUE: if (r_cmd_tvalid && cmd_tready) w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_grant      = (r_state == c_S_IDLE) && w_any_elig;
    w_issue_done = (r_state == c_S_ISSUE) && r_cmd_tvalid && cmd_tready;
  end

  // Command register; held stable for the whole ISSUE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_tdata  <= '0;
      r_cmd_chan   <= '0;
      r_cmd_tvalid <= 1'b0;
      r_last_grant <= '1;
      r_tag        <= '0;
    end else if (w_grant) begin
      r_cmd_tdata  <= {4'h0, r_tag, w_head_addr[w_sel],
                       1'b0, 1'b1, 6'h00, 1'b1, 23'(w_head_btt[w_sel])};
      r_cmd_chan   <= w_sel;
      r_cmd_tvalid <= 1'b1;
    end else if (w_issue_done) begin
      r_cmd_tvalid <= 1'b0;
      r_last_grant <= r_cmd_chan;
      r_tag        <= r_tag + 4'd1;
    end
  end

  //--------------------------------------------------------------------------
  // In-flight queue: pushed on grant, popped on status handshake
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_wr  <= '0;
      r_if_rd  <= '0;
      r_if_occ <= '0;
    end else begin
      if (w_grant)  r_if_wr <= r_if_wr + 1'b1;
      if (w_sts_hs) r_if_rd <= r_if_rd + 1'b1;
      case ({w_grant, w_sts_hs})
        2'b10:   r_if_occ <= r_if_occ + 1'b1;
        2'b01:   r_if_occ <= r_if_occ - 1'b1;
        default: r_if_occ <= r_if_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_if_mem[r_if_wr] <= {w_sel, r_tag};
  end

  //--------------------------------------------------------------------------
  // Readback and interrupt
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rb_data <= '0;
    end else if (rb_stb) begin
      if ((rb_addr[7:4] >> CHAN_WIDTH) != 4'd0) begin
        r_rb_data <= 32'hdeadbeef;
      end else begin
        case (rb_addr[3:0])
          4'd0:    r_rb_data <= w_rb0[rb_addr[4 +: CHAN_WIDTH]];
          4'd1:    r_rb_data <= w_rb1[rb_addr[4 +: CHAN_WIDTH]];
          4'd2:    r_rb_data <= w_rb2[rb_addr[4 +: CHAN_WIDTH]];
          default: r_rb_data <= 32'hdeadbeef;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= |w_irq_out;
  end

  assign rb_data    = r_rb_data;
  assign cmd_tdata  = r_cmd_tdata;
  assign cmd_tvalid = r_cmd_tvalid;
  assign cmd_chan   = r_cmd_chan;
  assign sts_tready = !w_if_empty;
  assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_zf_dma_scheduler.sv
`default_nettype none
//==============================================================================
// Module : tb_zf_dma_scheduler
// Brief  : Directed self-checking bench for zf_dma_scheduler (4 channels,
//          16-deep queues). Inputs change and outputs are sampled 1 ns after
//          each rising clock edge.
// Rev    : 1.0  initial release
//==============================================================================
module tb_zf_dma_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        rb_stb = 1'b0;
  logic [7:0]  rb_addr = '0;
  logic [31:0] rb_data;
  logic [3:0]  ch_ready = '0;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready = 1'b0;
  logic [1:0]  cmd_chan;
  logic [7:0]  sts_tdata = '0;
  logic        sts_tvalid = 1'b0;
  logic        sts_tready;
  logic        irq;

  int total = 0;
  int bad   = 0;

  zf_dma_scheduler #(
    .CHAN_WIDTH     (2),
    .CMD_DEPTH_LOG2 (4),
    .BTT_WIDTH      (23)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .rb_stb     (rb_stb),
    .rb_addr    (rb_addr),
    .rb_data    (rb_data),
    .ch_ready   (ch_ready),
    .cmd_tdata  (cmd_tdata),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .cmd_chan   (cmd_chan),
    .sts_tdata  (sts_tdata),
    .sts_tvalid (sts_tvalid),
    .sts_tready (sts_tready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = {ch[3:0], rg[3:0]};
    set_data = d;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic rd(input int ch, input int rg, output logic [31:0] v);
    rb_stb  = 1'b1;
    rb_addr = {ch[3:0], rg[3:0]};
    tick();
    rb_stb  = 1'b0;
    v = rb_data;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    set_stb    = 1'b0;
    rb_stb     = 1'b0;
    ch_ready   = '0;
    cmd_tready = 1'b0;
    sts_tvalid = 1'b0;
    sts_tdata  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic send_sts(input logic [7:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sts_tready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      sts_tvalid = 1'b1;
      sts_tdata  = s;
      tick();
      sts_tvalid = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (cmd_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", cmd_tvalid); end
    total++; if (cmd_tdata !== 72'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", cmd_tdata); end
    total++; if (cmd_chan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0d want=0", cmd_chan); end
    total++; if (sts_tready !== 1'b0) begin bad++; $display("FAIL reset_sts_tready got=%b want=0", sts_tready); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    total++; if (rb_data !== 32'h0) begin bad++; $display("FAIL reset_rb_data got=%h want=0", rb_data); end
  endtask

  task automatic test_single();
    logic [31:0] v;
    bit ok;
    do_reset();
    ch_ready   = 4'b0010;
    cmd_tready = 1'b1;
    wr(1, 0, 32'h1000_0000);
    wr(1, 1, 32'h0000_0200);
    total++; if (cmd_tvalid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", cmd_tvalid); end
    tick();
    total++; if (cmd_tvalid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", cmd_tvalid); end
    total++; if (cmd_tdata !== 72'h00_1000_0000_4080_0200) begin bad++; $display("FAIL single_tdata got=%h want=%h", cmd_tdata, 72'h00_1000_0000_4080_0200); end
    total++; if (cmd_chan !== 2'd1) begin bad++; $display("FAIL single_chan got=%0d want=1", cmd_chan); end
    tick();
    total++; if (cmd_tvalid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b want=0", cmd_tvalid); end
    total++; if (sts_tready !== 1'b1) begin bad++; $display("FAIL single_sts_tready got=%b want=1", sts_tready); end
    send_sts(8'h80, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_sts_wait got=timeout want=ready"); end
    rd(1, 0, v);
    total++; if (v !== 32'h0001_0001) begin bad++; $display("FAIL single_done_cnt got=%h want=00010001", v); end
    total++; if (sts_tready !== 1'b0) begin bad++; $display("FAIL single_inflight_empty got=%b want=0", sts_tready); end
  endtask

  task automatic test_round_robin();
    int exp_seq[9] = '{0, 2, 3, 0, 2, 3, 0, 2, 3};
    int got[9]     = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    int n = 0;
    do_reset();
    cmd_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr(0, 1, 32'h10 + k);
      wr(2, 1, 32'h20 + k);
      wr(3, 1, 32'h30 + k);
    end
    ch_ready = 4'b1111;
    for (int i = 0; i < 80 && n < 9; i++) begin
      if (cmd_tvalid && cmd_tready) begin
        got[n] = int'(cmd_chan);
        n++;
      end
      tick();
    end
    total++; if (n !== 9) begin bad++; $display("FAIL rr_count got=%0d want=9", n); end
    for (int k = 0; k < 9; k++) begin
      total++; if (got[k] !== exp_seq[k]) begin bad++; $display("FAIL rr_seq[%0d] got=%0d want=%0d", k, got[k], exp_seq[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    bit ok;
    do_reset();
    ch_ready   = 4'b0001;
    cmd_tready = 1'b0;
    wr(0, 0, 32'hAAAA_0000);
    wr(0, 1, 32'h0000_0010);
    wr(0, 0, 32'hBBBB_0000);
    wr(0, 1, 32'h0000_0020);
    wait_valid(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_wait_valid got=timeout want=valid"); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (cmd_tvalid !== 1'b1 || cmd_chan !== 2'd0 || cmd_tdata !== 72'h00_AAAA_0000_4080_0010) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=%b/%0d/%h want=1/0/%h", i, cmd_tvalid, cmd_chan, cmd_tdata, 72'h00_AAAA_0000_4080_0010);
      end
      tick();
    end
    rd(0, 1, v);
    total++; if (v !== 32'h0000_0001) begin bad++; $display("FAIL bp_occupancy got=%h want=00000001", v); end
    cmd_tready = 1'b1;
    tick();
    total++; if (cmd_tvalid !== 1'b0) begin bad++; $display("FAIL bp_gap got=%b want=0", cmd_tvalid); end
    tick();
    total++; if (cmd_tdata !== 72'h01_BBBB_0000_4080_0020) begin bad++; $display("FAIL bp_second got=%h want=%h", cmd_tdata, 72'h01_BBBB_0000_4080_0020); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    do_reset();
    for (int k = 0; k < 17; k++) wr(0, 1, 32'h40);
    rd(0, 1, v);
    total++; if (v !== 32'h8000_0010) begin bad++; $display("FAIL ovf_status got=%h want=80000010", v); end
    rd(0, 0, v);
    total++; if (v !== 32'h0800_0000) begin bad++; $display("FAIL ovf_bit got=%h want=08000000", v); end
    wr(0, 1, 32'h0);
    rd(0, 0, v);
    total++; if (v !== 32'h0C00_0000) begin bad++; $display("FAIL zlen_bit got=%h want=0C000000", v); end
    wr(0, 3, 32'h2);
    rd(0, 0, v);
    total++; if (v !== 32'h0000_0000) begin bad++; $display("FAIL err_ack got=%h want=00000000", v); end
    rd(2, 1, v);
    total++; if (v !== 32'h4000_0000) begin bad++; $display("FAIL empty_status got=%h want=40000000", v); end
    rd(0, 5, v);
    total++; if (v !== 32'hdeadbeef) begin bad++; $display("FAIL bad_reg got=%h want=deadbeef", v); end
  endtask

  task automatic test_coalesce();
    logic [31:0] v;
    bit ok;
    do_reset();
    ch_ready   = 4'b0100;
    cmd_tready = 1'b1;
    wr(2, 2, 32'h0000_0301);
    wr(2, 0, 32'h3000_0000);
    for (int k = 0; k < 3; k++) wr(2, 1, 32'h8);
    send_sts(8'h80, ok);
    send_sts(8'h81, ok);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL coal_irq_2 got=%b want=0", irq); end
    rd(2, 0, v);
    total++; if (v !== 32'h0002_0002) begin bad++; $display("FAIL coal_cnt_2 got=%h want=00020002", v); end
    send_sts(8'h82, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL coal_sts_wait got=timeout want=ready"); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coal_irq_3 got=%b want=1", irq); end
    rd(2, 0, v);
    total++; if (v !== 32'h0003_0003) begin bad++; $display("FAIL coal_cnt_3 got=%h want=00030003", v); end
    wr(2, 3, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL coal_irq_ack got=%b want=0", irq); end
    rd(2, 0, v);
    total++; if (v !== 32'h0000_0003) begin bad++; $display("FAIL coal_pend_clr got=%h want=00000003", v); end
    rd(2, 2, v);
    total++; if (v !== 32'h0000_0301) begin bad++; $display("FAIL coal_cfg got=%h want=00000301", v); end
    // ACK and completion together with threshold 1: count restarts at 1 and fires.
    wr(2, 2, 32'h0000_0101);
    wr(2, 1, 32'h8);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sts_tready) begin ok = 1'b1; break; end
      tick();
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL coal_sim_wait got=timeout want=ready"); end
    set_stb    = 1'b1;
    set_addr   = 8'h23;
    set_data   = 32'h1;
    sts_tvalid = 1'b1;
    sts_tdata  = 8'h83;
    tick();
    set_stb    = 1'b0;
    sts_tvalid = 1'b0;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coal_sim_irq got=%b want=1", irq); end
    rd(2, 0, v);
    total++; if (v !== 32'h0001_0004) begin bad++; $display("FAIL coal_sim_cnt got=%h want=00010004", v); end
  endtask

  task automatic test_errors();
    logic [31:0] v;
    bit ok;
    do_reset();
    ch_ready   = 4'b0001;
    cmd_tready = 1'b1;
    wr(0, 0, 32'h2000_0000);
    for (int k = 0; k < 5; k++) wr(0, 1, 32'h4);
    for (int k = 0; k < 4; k++) send_sts(8'h80 + 8'(k), ok);
    // Fifth command carries tag 4; status reports tag 4 without OKAY.
    send_sts(8'h44, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL err_sts_wait got=timeout want=ready"); end
    rd(0, 0, v);
    total++; if (v !== 32'h0105_0005) begin bad++; $display("FAIL err_dm got=%h want=01050005", v); end
    wr(0, 3, 32'h2);
    rd(0, 0, v);
    total++; if (v !== 32'h0005_0005) begin bad++; $display("FAIL err_ack got=%h want=00050005", v); end
    wr(0, 1, 32'h4);
    send_sts(8'h87, ok);
    rd(0, 0, v);
    total++; if (v !== 32'h0206_0006) begin bad++; $display("FAIL err_tag got=%h want=02060006", v); end
    // Reset in the middle of an ISSUE
    cmd_tready = 1'b0;
    wr(0, 1, 32'h4);
    wait_valid(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_wait_valid got=timeout want=valid"); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (cmd_tvalid !== 1'b0) begin bad++; $display("FAIL rst_async_tvalid got=%b want=0", cmd_tvalid); end
    total++; if (sts_tready !== 1'b0) begin bad++; $display("FAIL rst_async_sts got=%b want=0", sts_tready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    rd(0, 0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_counters got=%h want=00000000", v); end
    total++; if (cmd_tvalid !== 1'b0) begin bad++; $display("FAIL rst_no_reissue got=%b want=0", cmd_tvalid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_coalesce();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
